// File: rtl/ringbuffer_readout_ctrl_pkg.sv
// Shared types and constants for the ADC ring-buffer readout sequencer.
// DEPTH is the default buffer depth; the top derives its default SIZE from it.
package ringbuffer_readout_ctrl_pkg;

    localparam int SIZE_DEF  = 12;
    localparam int WIDTH_DEF = 14;
    localparam int DEPTH     = 2 ** SIZE_DEF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_ARMED,
        ST_POST,
        ST_READ
    } state_e;

endpackage

// File: rtl/ringbuffer_readout_ctrl.sv
// Trigger-driven ring-buffer sequencer: fills pre-trigger history, captures
// post-trigger samples, then streams the window out in time order.
module ringbuffer_readout_ctrl
    import ringbuffer_readout_ctrl_pkg::*;
#(
    parameter int SIZE  = $clog2(DEPTH),
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             arm,
    input  logic [SIZE-1:0]  cfg_pre,
    input  logic [SIZE-1:0]  cfg_post,
    input  logic             adc_valid,
    input  logic             trig,
    output logic             rb_wr_en,
    output logic             rb_rd_en,
    output logic [SIZE-1:0]  rb_ain,
    input  logic [SIZE-1:0]  rb_aout,
    input  logic [WIDTH-1:0] rb_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             trig_lost,
    output logic             cfg_err
);

    localparam logic [SIZE:0] WIN_MAX = {1'b1, {SIZE{1'b0}}};

    state_e          state_q, state_d;
    logic [SIZE-1:0] pre_q, pre_d;
    logic [SIZE-1:0] post_q, post_d;
    logic [SIZE-1:0] fill_q, fill_d;
    logic [SIZE-1:0] post_cnt_q, post_cnt_d;
    logic [SIZE-1:0] start_q, start_d;
    logic [SIZE-1:0] rd_addr_q, rd_addr_d;
    logic [SIZE:0]   rd_rem_q, rd_rem_d;
    logic            ov_q, ov_d;
    logic            last_q, last_d;
    logic            lost_q, lost_d;
    logic            err_q, err_d;

    logic [SIZE:0]   cfg_sum;
    logic            cfg_ok;
    logic [SIZE:0]   win_len;
    logic            hs;
    logic            rd_go;
    logic            wr;
    logic [SIZE-1:0] post_left;
    logic [SIZE-1:0] trig_start;

    assign cfg_sum    = {1'b0, cfg_pre} + {1'b0, cfg_post};
    assign cfg_ok     = (cfg_post != '0) && (cfg_sum <= WIN_MAX);
    assign win_len    = {1'b0, pre_q} + {1'b0, post_q};
    assign hs         = ov_q & out_ready;
    // A new read may only be issued when the output slot frees up this cycle.
    assign rd_go      = (state_q == ST_READ) && (rd_rem_q != '0) && (!ov_q || out_ready);
    assign post_left  = post_q - {{(SIZE-1){1'b0}}, adc_valid};
    assign trig_start = rb_aout - pre_q;

    always_comb begin
        state_d    = state_q;
        pre_d      = pre_q;
        post_d     = post_q;
        fill_d     = fill_q;
        post_cnt_d = post_cnt_q;
        start_d    = start_q;
        rd_addr_d  = rd_addr_q;
        rd_rem_d   = rd_rem_q;
        err_d      = err_q;
        lost_d     = 1'b0;
        wr         = 1'b0;
        ov_d       = ov_q;
        last_d     = last_q;

        if (rd_go) begin
            ov_d   = 1'b1;
            last_d = (rd_rem_q == (SIZE+1)'(1));
        end else if (hs) begin
            ov_d   = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (arm) begin
                    pre_d  = cfg_pre;
                    post_d = cfg_post;
                    if (cfg_ok) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                wr     = adc_valid;
                lost_d = trig;
                if (pre_q == '0) begin
                    state_d = ST_ARMED;
                end else if (adc_valid) begin
                    fill_d = fill_q + SIZE'(1);
                    if (fill_q + SIZE'(1) == pre_q)
                        state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                wr = adc_valid;
                if (trig) begin
                    start_d    = trig_start;
                    post_cnt_d = post_left;
                    // post = 1 with a coincident write completes the window now.
                    if (post_left == '0) begin
                        state_d   = ST_READ;
                        rd_addr_d = trig_start;
                        rd_rem_d  = win_len;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                wr     = adc_valid;
                lost_d = trig;
                if (adc_valid) begin
                    post_cnt_d = post_cnt_q - SIZE'(1);
                    if (post_cnt_q == SIZE'(1)) begin
                        state_d   = ST_READ;
                        rd_addr_d = start_q;
                        rd_rem_d  = win_len;
                    end
                end
            end
            ST_READ: begin
                lost_d = trig;
                if (rd_go) begin
                    rd_addr_d = rd_addr_q + SIZE'(1);
                    rd_rem_d  = rd_rem_q - (SIZE+1)'(1);
                end
                if (hs && last_q) begin
                    if (arm) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            post_q     <= '0;
            fill_q     <= '0;
            post_cnt_q <= '0;
            start_q    <= '0;
            rd_addr_q  <= '0;
            rd_rem_q   <= '0;
            ov_q       <= 1'b0;
            last_q     <= 1'b0;
            lost_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            post_q     <= post_d;
            fill_q     <= fill_d;
            post_cnt_q <= post_cnt_d;
            start_q    <= start_d;
            rd_addr_q  <= rd_addr_d;
            rd_rem_q   <= rd_rem_d;
            ov_q       <= ov_d;
            last_q     <= last_d;
            lost_q     <= lost_d;
            err_q      <= err_d;
        end
    end

    assign rb_wr_en  = wr;
    assign rb_rd_en  = rd_go;
    assign rb_ain    = rd_addr_q;
    assign out_data  = rb_dout;
    assign out_valid = ov_q;
    assign out_last  = ov_q & last_q;
    assign busy      = (state_q == ST_POST) || (state_q == ST_READ);
    assign trig_lost = lost_q;
    assign cfg_err   = err_q;

endmodule
